fp_alu_seq: RTL and testbench

- Parametrised, multi-cycle successor to the combinational FP ALU.
- Implements IEEE-754-style add, sub, mul and div for any exponent/fraction width, plus the same bitwise ops.
- Uses valid/ready handshakes on input and output, and an iterative divider.
- Sits between the operand register file and the writeback stage, one operation in flight at a time.

---
 rtl/fp_alu_seq.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_fp_alu_seq.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fp_alu_seq.sv
// Multi-cycle IEEE-754-style FP ALU (add/sub/mul/div + bitwise) with valid/ready handshakes.
// Define FP_ALU_RNE_EN for round-to-nearest-even; otherwise results truncate toward zero.
module fp_alu_seq #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int TAG_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [EXP_W+FRAC_W:0]     op_a,
  input  logic [EXP_W+FRAC_W:0]     op_b,
  input  logic [2:0]                selop,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+FRAC_W:0]     result,
  output logic [TAG_W-1:0]          out_tag,
  output logic                      parity,
  output logic                      overflow,
  output logic                      underflow,
  output logic                      invalid,
  output logic                      div_by_zero,
  output logic                      busy
);
  localparam int W   = 1 + EXP_W + FRAC_W;
  localparam int MW  = FRAC_W + 1;
  localparam int XW  = 2 * MW + 2;
  localparam int LZW = $clog2(XW) + 1;
  localparam int EW  = ((EXP_W > LZW) ? EXP_W : LZW) + 2;
  localparam int CW  = $clog2(FRAC_W + 3);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EW-1:0]    BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW-1:0]    EMAX = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0]     QNAN = {1'b0, EXP_ONES, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_DIV = 3'd3;
  localparam logic [2:0] OP_NOT = 3'd4, OP_NAND = 3'd5, OP_SHR = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_NORM, S_HOLD} state_t;

  state_t             r_state;
  logic               r_phase;
  logic [W-1:0]       r_a, r_b;
  logic [2:0]         r_op;
  logic [TAG_W-1:0]   r_tag;
  logic               r_sa, r_sb, r_sign;
  logic [EXP_W-1:0]   r_ea, r_eb;
  logic [MW-1:0]      r_ma, r_mb;
  logic               r_spec, r_spec_inv, r_spec_dbz;
  logic [W-1:0]       r_spec_word;
  logic [EW-1:0]      r_exp;
  logic [XW-1:0]      r_m;
  logic [MW:0]        r_rem;
  logic [FRAC_W+1:0]  r_q;
  logic [CW-1:0]      r_cnt;

  // Operand unpacking; subnormal inputs collapse to signed zero.
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MW-1:0]    w_ma, w_mb;
  logic             w_sa, w_sb, w_sx;
  logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;

  assign w_ea     = r_a[W-2:FRAC_W];
  assign w_eb     = r_b[W-2:FRAC_W];
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (w_ea == EXP_ONES) && (r_a[FRAC_W-1:0] == '0);
  assign w_b_inf  = (w_eb == EXP_ONES) && (r_b[FRAC_W-1:0] == '0);
  assign w_a_nan  = (w_ea == EXP_ONES) && (r_a[FRAC_W-1:0] != '0);
  assign w_b_nan  = (w_eb == EXP_ONES) && (r_b[FRAC_W-1:0] != '0);
  assign w_ma     = w_a_zero ? '0 : {1'b1, r_a[FRAC_W-1:0]};
  assign w_mb     = w_b_zero ? '0 : {1'b1, r_b[FRAC_W-1:0]};
  assign w_sa     = r_a[W-1];
  assign w_sb     = r_b[W-1] ^ (r_op == OP_SUB);
  assign w_sx     = r_a[W-1] ^ r_b[W-1];

  logic             w_spec, w_spec_inv, w_spec_dbz;
  logic [W-1:0]     w_spec_word;

  always_comb begin
    w_spec      = 1'b1;
    w_spec_word = '0;
    w_spec_inv  = 1'b0;
    w_spec_dbz  = 1'b0;
    case (r_op)
      OP_NOT:  w_spec_word = ~r_a;
      OP_NAND: w_spec_word = ~(r_a & r_b);
      OP_SHR:  w_spec_word = r_a >> 1;
      3'd7:    w_spec_word = '0;
      default: begin
        if (w_a_nan || w_b_nan) begin
          w_spec_word = QNAN;
          w_spec_inv  = 1'b1;
        end else if (r_op == OP_ADD || r_op == OP_SUB) begin
          if (w_a_inf && w_b_inf && (w_sa != w_sb)) begin
            w_spec_word = QNAN;
            w_spec_inv  = 1'b1;
          end else if (w_a_inf) w_spec_word = {w_sa, EXP_ONES, {FRAC_W{1'b0}}};
          else if (w_b_inf)     w_spec_word = {w_sb, EXP_ONES, {FRAC_W{1'b0}}};
          else                  w_spec = 1'b0;
        end else if (r_op == OP_MUL) begin
          if ((w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) begin
            w_spec_word = QNAN;
            w_spec_inv  = 1'b1;
          end else if (w_a_inf || w_b_inf) w_spec_word = {w_sx, EXP_ONES, {FRAC_W{1'b0}}};
          else                             w_spec = 1'b0;
        end else begin
          if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec_word = QNAN;
            w_spec_inv  = 1'b1;
          end else if (w_a_inf) w_spec_word = {w_sx, EXP_ONES, {FRAC_W{1'b0}}};
          else if (w_b_zero) begin
            w_spec_word = {w_sx, EXP_ONES, {FRAC_W{1'b0}}};
            w_spec_dbz  = 1'b1;
          end else if (w_b_inf || w_a_zero) w_spec_word = {w_sx, {(W-1){1'b0}}};
          else                              w_spec = 1'b0;
        end
      end
    endcase
  end

  // Divider pre-shift keeps the quotient in [1,2) so the last iteration is always a guard bit.
  logic          w_div_pre;
  logic [MW:0]   w_rem0;
  logic [EW-1:0] w_div_exp;
  assign w_div_pre = (w_ma < w_mb);
  assign w_rem0    = w_div_pre ? {w_ma, 1'b0} : {1'b0, w_ma};
  assign w_div_exp = EW'(w_ea) - EW'(w_eb) + BIAS - EW'(w_div_pre);

  logic              w_rem_ge, w_div_st;
  logic [MW:0]       w_rem_sub;
  logic [FRAC_W+1:0] w_q_next;
  assign w_rem_ge  = (r_rem >= {1'b0, r_mb});
  assign w_rem_sub = w_rem_ge ? (r_rem - {1'b0, r_mb}) : r_rem;
  assign w_q_next  = {r_q[FRAC_W:0], w_rem_ge};

  // Add/sub alignment: the larger magnitude sits with its hidden bit at XW-2.
  logic             w_a_big, w_s_big;
  logic [EXP_W-1:0] w_e_big, w_e_sml, w_shift;
  logic [MW-1:0]    w_m_big, w_m_sml;
  logic [XW-1:0]    w_x_big, w_x_sml, w_x_sh, w_x_al, w_sum;
  assign w_a_big = ({r_ea, r_ma} >= {r_eb, r_mb});
  assign w_e_big = w_a_big ? r_ea : r_eb;
  assign w_e_sml = w_a_big ? r_eb : r_ea;
  assign w_m_big = w_a_big ? r_ma : r_mb;
  assign w_m_sml = w_a_big ? r_mb : r_ma;
  assign w_s_big = w_a_big ? r_sa : r_sb;
  assign w_shift = w_e_big - w_e_sml;
  assign w_x_big = {1'b0, w_m_big, {(MW+1){1'b0}}};
  assign w_x_sml = {1'b0, w_m_sml, {(MW+1){1'b0}}};
  assign w_x_sh  = w_x_sml >> w_shift;
`ifdef FP_ALU_RNE_EN
  assign w_x_al   = {w_x_sh[XW-1:1], w_x_sh[0] | ((w_x_sh << w_shift) != w_x_sml)};
  assign w_div_st = (w_rem_sub != '0);
`else
  assign w_x_al   = w_x_sh;
  assign w_div_st = 1'b0;
`endif
  assign w_sum = (r_sa != r_sb) ? (w_x_big - w_x_al) : (w_x_big + w_x_al);

  logic [2*MW-1:0] w_prod;
  logic [EW-1:0]   w_mul_exp;
  assign w_prod    = {{MW{1'b0}}, r_ma} * {{MW{1'b0}}, r_mb};
  assign w_mul_exp = EW'(r_ea) + EW'(r_eb) - BIAS;

  // Normalisation: move the leading one to XW-1, then round and classify the exponent.
  logic [LZW-1:0]    w_lz;
  logic [XW-1:0]     w_m_n;
  logic [EW-1:0]     w_e_n, w_e_f;
  logic [FRAC_W-1:0] w_frac, w_frac_f;

  always_comb begin
    w_lz = '0;
    for (int i = 0; i < XW; i++)
      if (r_m[i]) w_lz = LZW'(XW - 1 - i);
  end

  assign w_m_n  = r_m << w_lz;
  assign w_e_n  = r_exp + EW'(1) - EW'(w_lz);
  assign w_frac = w_m_n[XW-2 -: FRAC_W];

`ifdef FP_ALU_RNE_EN
  logic            w_g, w_st, w_up;
  logic [FRAC_W:0] w_rnd;
  assign w_g      = w_m_n[XW-2-FRAC_W];
  assign w_st     = |w_m_n[XW-3-FRAC_W:0];
  assign w_up     = w_g & (w_st | w_frac[0]);
  assign w_rnd    = {1'b0, w_frac} + {{FRAC_W{1'b0}}, w_up};
  assign w_frac_f = w_rnd[FRAC_W-1:0];
  assign w_e_f    = w_e_n + EW'(w_rnd[FRAC_W]);
  logic w_unused;
  assign w_unused = ^{w_m_n[XW-1], r_q[FRAC_W+1], w_rem_sub[MW]};
`else
  assign w_frac_f = w_frac;
  assign w_e_f    = w_e_n;
  logic w_unused;
  assign w_unused = ^{w_m_n[XW-1], w_m_n[XW-2-FRAC_W:0], r_q[FRAC_W+1], w_rem_sub};
`endif

  logic [W-1:0] w_res;
  logic         w_ovf, w_unf, w_inv, w_dbz;

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_unf = 1'b0;
    w_inv = 1'b0;
    w_dbz = 1'b0;
    if (r_spec) begin
      w_res = r_spec_word;
      w_inv = r_spec_inv;
      w_dbz = r_spec_dbz;
    end else if (r_m == '0) begin
      w_res = {r_sign, {(W-1){1'b0}}};
    end else if ($signed(w_e_f) >= $signed(EMAX)) begin
      w_res = {r_sign, EXP_ONES, {FRAC_W{1'b0}}};
      w_ovf = 1'b1;
    end else if ($signed(w_e_f) < $signed(EW'(1))) begin
      w_res = {r_sign, {(W-1){1'b0}}};
      w_unf = 1'b1;
    end else begin
      w_res = {r_sign, w_e_f[EXP_W-1:0], w_frac_f};
    end
  end

  assign in_ready = (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_phase     <= 1'b0;
      out_valid   <= 1'b0;
      result      <= '0;
      out_tag     <= '0;
      parity      <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      invalid     <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_op    <= selop;
            r_tag   <= in_tag;
            r_phase <= 1'b0;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!r_phase) begin
            r_phase     <= 1'b1;
            r_sa        <= w_sa;
            r_sb        <= w_sb;
            r_ea        <= w_ea;
            r_eb        <= w_eb;
            r_ma        <= w_ma;
            r_mb        <= w_mb;
            r_spec      <= w_spec;
            r_spec_word <= w_spec_word;
            r_spec_inv  <= w_spec_inv;
            r_spec_dbz  <= w_spec_dbz;
            r_sign      <= w_sx;
            r_exp       <= w_div_exp;
            r_rem       <= w_rem0;
            r_q         <= '0;
            r_cnt       <= CW'(FRAC_W + 2);
          end else if (r_op == OP_DIV) begin
            r_rem <= {w_rem_sub[MW-1:0], 1'b0};
            r_q   <= w_q_next;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
              r_m     <= {1'b0, w_q_next, {FRAC_W{1'b0}}, w_div_st};
              r_state <= S_NORM;
            end
          end else begin
            if (r_op == OP_MUL) begin
              r_m   <= {w_prod, 2'b00};
              r_exp <= w_mul_exp;
            end else begin
              r_m    <= w_sum;
              r_exp  <= EW'(w_e_big);
              r_sign <= (w_sum == '0) ? 1'b0 : w_s_big;
            end
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          result      <= w_res;
          parity      <= ^w_res;
          overflow    <= w_ovf;
          underflow   <= w_unf;
          invalid     <= w_inv;
          div_by_zero <= w_dbz;
          out_tag     <= r_tag;
          out_valid   <= 1'b1;
          r_state     <= S_HOLD;
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fp_alu_seq.sv
// Directed scoreboard bench for fp_alu_seq at default parameters (binary32 layout).
module tb_fp_alu_seq;
  localparam int W = 32;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]     op_a, op_b, result;
  logic [2:0]       selop;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic             parity, overflow, underflow, invalid, div_by_zero, busy;

  fp_alu_seq #(.EXP_W(8), .FRAC_W(23), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .selop(selop), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_tag(out_tag),
    .parity(parity), .overflow(overflow), .underflow(underflow), .invalid(invalid),
    .div_by_zero(div_by_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]     res;
    logic [TAG_W-1:0] tag;
    logic [3:0]       flags;  // {overflow, underflow, invalid, div_by_zero}
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, expv);
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] sel, input logic [TAG_W-1:0] tag,
                        input logic [W-1:0] exp_res, input logic [3:0] exp_flags,
                        input int exp_lat, input int hold);
    exp_t e;
    int   lat;
    sb_q.push_back('{res: exp_res, tag: tag, flags: exp_flags});
    @(negedge clk);
    check({name, ":in_ready"}, 64'(in_ready), 64'(1'b1));
    op_a = a; op_b = b; selop = sel; in_tag = tag; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({name, ":busy"}, 64'(busy), 64'(1'b1));
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, ":latency"}, 64'(lat), 64'(exp_lat));
    e = sb_q.pop_front();
    check({name, ":result"}, 64'(result), 64'(e.res));
    check({name, ":tag"}, 64'(out_tag), 64'(e.tag));
    check({name, ":flags"}, 64'({overflow, underflow, invalid, div_by_zero}), 64'(e.flags));
    check({name, ":parity"}, 64'(parity), 64'(^e.res));
    $display("op %-10s a=%h b=%h sel=%0d -> result=%h tag=%0d flags=%b lat=%0d",
             name, a, b, sel, result, out_tag, {overflow, underflow, invalid, div_by_zero}, lat);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      op_a = $urandom; op_b = $urandom; selop = 3'd0; in_tag = 4'hF;
      @(posedge clk); #1;
      check({name, ":hold_result"}, 64'(result), 64'(e.res));
      check({name, ":hold_tag"}, 64'(out_tag), 64'(e.tag));
      check({name, ":hold_in_ready"}, 64'(in_ready), 64'(1'b0));
      check({name, ":hold_valid"}, 64'(out_valid), 64'(1'b1));
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, ":release_in_ready"}, 64'(in_ready), 64'(1'b1));
    check({name, ":release_valid"}, 64'(out_valid), 64'(1'b0));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; selop = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset:out_valid", 64'(out_valid), 64'(1'b0));
    check("reset:result", 64'(result), 64'(0));
    check("reset:out_tag", 64'(out_tag), 64'(0));
    check("reset:flags", 64'({overflow, underflow, invalid, div_by_zero, parity}), 64'(0));
    check("reset:in_ready", 64'(in_ready), 64'(1'b1));
    check("reset:busy", 64'(busy), 64'(1'b0));
    @(negedge clk);
    rst = 1'b0;

    run_op("add_1p2",  32'h3F800000, 32'h40000000, 3'd0, 4'd5, 32'h40400000, 4'b0000, 3, 0);
    run_op("div_6d2",  32'h40C00000, 32'h40000000, 3'd3, 4'd1, 32'h40400000, 4'b0000, 27, 0);
    run_op("div_by0",  32'h3F800000, 32'h00000000, 3'd3, 4'd2, 32'h7F800000, 4'b0001, 27, 0);
    run_op("mul_ovf",  32'h7F000000, 32'h40000000, 3'd2, 4'd3, 32'h7F800000, 4'b1000, 3, 0);
    run_op("mul_unf",  32'h00800000, 32'h00800000, 3'd2, 4'd4, 32'h00000000, 4'b0100, 3, 0);
    run_op("sub_inf",  32'h7F800000, 32'h7F800000, 3'd1, 4'd6, 32'h7FC00000, 4'b0010, 3, 0);
    run_op("add_nan",  32'h7FC00001, 32'h3F800000, 3'd0, 4'd7, 32'h7FC00000, 4'b0010, 3, 0);
    run_op("sub_3m1",  32'h40400000, 32'h3F800000, 3'd1, 4'd8, 32'h40000000, 4'b0000, 3, 5);
    run_op("sub_zero", 32'h3F800000, 32'h3F800000, 3'd1, 4'd9, 32'h00000000, 4'b0000, 3, 0);
    run_op("mul_3x3",  32'h40400000, 32'h40400000, 3'd2, 4'd10, 32'h41100000, 4'b0000, 3, 0);
    run_op("rnd_even", 32'h3F800000, 32'h33800000, 3'd0, 4'd11, 32'h3F800000, 4'b0000, 3, 0);
`ifdef FP_ALU_RNE_EN
    run_op("rnd_odd",  32'h3F800001, 32'h33800000, 3'd0, 4'd12, 32'h3F800002, 4'b0000, 3, 0);
    run_op("div_1d3",  32'h3F800000, 32'h40400000, 3'd3, 4'd13, 32'h3EAAAAAB, 4'b0000, 27, 0);
`else
    run_op("rnd_odd",  32'h3F800001, 32'h33800000, 3'd0, 4'd12, 32'h3F800001, 4'b0000, 3, 0);
    run_op("div_1d3",  32'h3F800000, 32'h40400000, 3'd3, 4'd13, 32'h3EAAAAAA, 4'b0000, 27, 0);
`endif
    run_op("not",      32'h3F800000, 32'h00000000, 3'd4, 4'd14, 32'hC07FFFFF, 4'b0000, 3, 0);
    run_op("nand",     32'hF0F0F0F0, 32'hFF00FF00, 3'd5, 4'd15, 32'h0FFF0FFF, 4'b0000, 3, 0);
    run_op("shr",      32'h80000001, 32'h00000000, 3'd6, 4'd0, 32'h40000000, 4'b0000, 3, 0);
    run_op("zero",     32'h12345678, 32'h9ABCDEF0, 3'd7, 4'd1, 32'h00000000, 4'b0000, 3, 0);
    run_op("nand_nz",  32'h0F0F0F0F, 32'hFFFF0000, 3'd5, 4'd2, 32'hF0F0FFFF, 4'b0000, 3, 0);

    // Abort a divide partway through its iterations.
    @(negedge clk);
    op_a = 32'h40C00000; op_b = 32'h40000000; selop = 3'd3; in_tag = 4'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort:out_valid", 64'(out_valid), 64'(1'b0));
    check("abort:busy", 64'(busy), 64'(1'b0));
    check("abort:in_ready", 64'(in_ready), 64'(1'b1));
    check("abort:result", 64'(result), 64'(0));
    check("abort:out_tag", 64'(out_tag), 64'(0));
    $display("op %-10s reset asserted during divide", "abort");
    @(negedge clk);
    rst = 1'b0;
    run_op("add_after", 32'h3F800000, 32'h40000000, 3'd0, 4'd9, 32'h40400000, 4'b0000, 3, 0);

    check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
